// File: rtl/classify_pkg.sv
// Shared widths, constants and FSM state encoding for the classification sequencer.
package classify_pkg;

  localparam int NUM_CLASSES = 10;
  localparam int PC_W        = 9;
  localparam int IDX_W       = 4;
  localparam int CONF_W      = 12;
  localparam int DIV_W       = PC_W + 7;
  localparam int TOTAL_W     = 12;
  localparam int PERCENT     = 100;
  localparam int CNT_W       = $clog2(DIV_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DIV,
    DONE
  } state_t;

endpackage

// File: rtl/classify_sequencer_divider.sv
// Restoring serial divider: one quotient bit per cycle, MSB first, floored result.
module serial_divider
  import classify_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DIV_W-1:0]   dividend,
  input  logic [TOTAL_W-1:0] divisor,
  output logic               done,
  output logic [CONF_W-1:0]  quotient
);

  logic [TOTAL_W:0]   r_rem;
  logic [DIV_W-1:0]   r_shift;
  logic [TOTAL_W-1:0] r_divisor;
  logic [CNT_W-1:0]   r_count;

  logic [TOTAL_W:0]   w_trial;
  logic [TOTAL_W:0]   w_diff;
  logic               w_fits;
  logic [DIV_W-1:0]   w_shift_next;

  // Dividend bits leave the top of r_shift while quotient bits enter at the bottom.
  always_comb begin
    w_trial      = {r_rem[TOTAL_W-1:0], r_shift[DIV_W-1]};
    w_diff       = w_trial - {1'b0, r_divisor};
    w_fits       = r_rem[TOTAL_W] | (w_trial >= {1'b0, r_divisor});
    w_shift_next = {r_shift[DIV_W-2:0], w_fits};
  end

  // done flags the final iteration; quotient is the value that iteration completes.
  assign done     = (r_count == CNT_W'(1));
  assign quotient = w_shift_next[CONF_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem     <= '0;
      r_shift   <= '0;
      r_divisor <= '0;
      r_count   <= '0;
    end else if (start) begin
      r_rem     <= '0;
      r_shift   <= dividend;
      r_divisor <= divisor;
      r_count   <= CNT_W'(DIV_W);
    end else if (r_count != '0) begin
      r_rem     <= w_fits ? w_diff : w_trial;
      r_shift   <= w_shift_next;
      r_count   <= r_count - CNT_W'(1);
    end
  end

endmodule

// File: rtl/classify_sequencer.sv
// Time-multiplexed argmax/confidence sequencer: one popcount request per class, then a serial divide.
module classify_sequencer
  import classify_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_valid,
  output logic              start_ready,
  output logic              pc_req,
  output logic [IDX_W-1:0]  pc_class,
  input  logic              pc_ack,
  input  logic [PC_W-1:0]   pc_value,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [IDX_W-1:0]  res_index,
  output logic [CONF_W-1:0] res_confidence,
  output logic              busy
);

  state_t             r_state;
  logic [PC_W-1:0]    r_max;
  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W-1:0]   r_class;
  logic [TOTAL_W-1:0] r_total;
  logic [IDX_W-1:0]   r_res_index;
  logic [CONF_W-1:0]  r_res_conf;

  logic               w_better;
  logic               w_last;
  logic [PC_W-1:0]    w_max_next;
  logic [IDX_W-1:0]   w_idx_next;
  logic [TOTAL_W-1:0] w_total_next;
  logic [DIV_W-1:0]   w_dividend;
  logic               w_div_start;
  logic               w_div_done;
  logic [CONF_W-1:0]  w_quotient;

  // The divider is loaded on the final ack using next-state max/total, so DIV starts iterating at once.
  always_comb begin
    w_better     = pc_value > r_max;
    w_max_next   = w_better ? pc_value : r_max;
    w_idx_next   = w_better ? r_class : r_idx;
    w_total_next = r_total + TOTAL_W'(pc_value);
    w_last       = (r_class == IDX_W'(NUM_CLASSES - 1));
    w_dividend   = DIV_W'(w_max_next) * DIV_W'(PERCENT);
    w_div_start  = (r_state == ISSUE) && pc_ack && w_last && (w_total_next != '0);
  end

  serial_divider u_divider (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (w_div_start),
    .dividend (w_dividend),
    .divisor  (w_total_next),
    .done     (w_div_done),
    .quotient (w_quotient)
  );

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_max       <= '0;
      r_idx       <= '0;
      r_class     <= '0;
      r_total     <= '0;
      r_res_index <= '0;
      r_res_conf  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_max   <= '0;
            r_idx   <= '0;
            r_total <= '0;
            r_class <= '0;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (pc_ack) begin
            r_max   <= w_max_next;
            r_idx   <= w_idx_next;
            r_total <= w_total_next;
            if (w_last) r_state <= DIV;
            else        r_class <= r_class + IDX_W'(1);
          end
        end
        DIV: begin
          if (r_total == '0) begin
            r_res_conf  <= '0;
            r_res_index <= r_idx;
            r_state     <= DONE;
          end else if (w_div_done) begin
            r_res_conf  <= w_quotient;
            r_res_index <= r_idx;
            r_state     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign start_ready    = (r_state == IDLE);
  assign busy           = (r_state != IDLE);
  assign pc_req         = (r_state == ISSUE);
  assign pc_class       = r_class;
  assign res_valid      = (r_state == DONE);
  assign res_index      = r_res_index;
  assign res_confidence = r_res_conf;

endmodule

// File: doc/classify_sequencer.md
# classify_sequencer

Sequences one classification of the binarized MNIST network: on a start handshake it requests the popcount for each of the output classes from the shared XNOR-popcount unit, one at a time. It tracks the running argmax and total as results arrive, then computes confidence (max·100/total, floored) with a serial divider. The result is held on a valid/ready output port. It replaces the parallel single-cycle argmax with a time-multiplexed datapath, and sits between the popcount unit and the result/display logic.

## Interface
- NUM_CLASSES, 10, number of output classes (one popcount request each)
- PC_W, 9, popcount width (values 0–400)
- IDX_W, 4, class index width
- CONF_W, 12, confidence output width (values 0–100)
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset; asynchronous, active-low
- start_valid  in  1  image loaded, classification requested
- start_ready  out  1  high only in IDLE
- pc_req  out  1  popcount request to shared unit
- pc_class  out  IDX_W  class (weight row) being requested
- pc_ack  in  1  pc_value valid for pc_class this cycle
- pc_value  in  PC_W  popcount result
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_index  out  IDX_W  argmax class, 0-based
- res_confidence  out  CONF_W  confidence percent, 0–100
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, DIV, DONE.
- IDLE: start_ready=1. On start_valid, clear max=0, idx=0, total=0, class=0, and go to ISSUE.
- ISSUE: pc_req=1, pc_class=class.
  - On pc_ack: if pc_value > max (strict), max←pc_value and idx←class. Ties keep the lower index.
  - Also on pc_ack: total←total+pc_value.
  - If class==NUM_CLASSES−1, go to DIV; otherwise class←class+1 and stay in ISSUE.
  - No pc_ack: hold pc_req and pc_class; wait indefinitely.
- pc_ack outside ISSUE is ignored.
- Widths:
  - total is 12 bits (max 4000, no overflow).
  - dividend = max·100 is 16 bits (DIV_W=PC_W+7).
  - Remainder register is 13 bits.
- DIV:
  - If total==0: confidence=0 and DIV lasts 1 cycle.
  - Otherwise: restoring division, one quotient bit per cycle, DIV_W=16 cycles, MSB first. Quotient is floored.
- DONE: res_valid=1; res_index and res_confidence are held stable. On res_ready, go to IDLE.
- start_valid while not in IDLE is ignored; it is not queued.

## Timing
- Reset values:
  - start_ready=1, busy=0, pc_req=0, pc_class=0.
  - res_valid=0, res_index=0, res_confidence=0.
  - Internal: state=IDLE, max=0, total=0, idx=0.
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Start accepted at cycle T (start_valid & start_ready):
  - pc_req first high at T+1 with pc_class=0.
  - With pc_ack high every requested cycle, pc_class steps 0..9 over T+1..T+10.
- Back-to-back acks are supported; each ack advances pc_class on the next cycle.
- DIV occupies T+11..T+26. res_valid rises at T+27.
- All-zero case: res_valid rises at T+12.
- Popcount stalls add cycles 1:1.
- res_valid & res_ready at cycle R: IDLE at R+1 (start_ready=1, res_valid=0).
- A new start is accepted no earlier than R+1.
- res_index and res_confidence keep their last values after the handshake until the next DONE.
- rst_n low in any state: immediate return to reset values, partial results discarded, pc_req drops asynchronously.

## Structure
- Package classify_pkg holds:
  - NUM_CLASSES, PC_W, IDX_W, CONF_W, DIV_W
  - TOTAL_W=12, the constant 100
  - state enum {IDLE, ISSUE, DIV, DONE}
- Sub-module serial_divider (restoring) contains:
  - ports: start, dividend[DIV_W], divisor[TOTAL_W], done, quotient[CONF_W]
  - its own bit counter
  - same clk/rst_n
- The FSM, accumulator and argmax stay in classify_sequencer.

## Test plan
- All ten popcounts = 40, ack every cycle → res_index=0, res_confidence=10; res_valid at T+27.
- Class 6 = 400, others 0 → res_index=6, res_confidence=100.
- Classes 3 and 7 = 200, others 0 → res_index=3 (tie to lower), res_confidence=50.
- All zero → res_index=0, res_confidence=0; res_valid at T+12, DIV skipped.
- Each popcount ack delayed by 3 cycles, values 1..10 → res_index=9, res_confidence=18 (1000/55 floored).
  - pc_class holds during stalls.
  - res_ready low for 5 cycles: outputs stable, start_ready=0, extra start_valid ignored.
- rst_n pulsed low mid-DIV → all outputs return to reset values at once; a fresh run then completes correctly.
